// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Lets two requesters share one external 8-bit combinational ALU. Port 0 is
//   the execute stage and port 1 is the address/aux unit. Only one operation
//   is in flight at a time. The arbiter registers the winner's operands into
//   the ALU, samples the ALU result and flags one cycle later, and returns a
//   one-cycle response to the winner. It also keeps an architectural flag
//   register for each requester.
//
//   Sequence:   IDLE --(any req)--> EXEC --> RESP --> IDLE
//   Timing:     a request sampled at edge k is acked during cycle k+1 and
//               answered (rsp_valid*) during cycle k+2. The earliest next
//               grant is at edge k+3.
//
// Parameters:
//   PRIO_FIXED   0 = round-robin on a tie; 1 = port 0 always wins a tie
//   OP_ADD       ALU add opcode; the result and all four flags are valid
//   OP_PASS      ALU pass-in1 opcode; only the result is valid
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req0/req1                  request, held with operands until its ack
//   a0/a1, b0/b1               operand 1 / operand 2 of each requester
//   op0/op1                    opcode of each requester
//   ack0/ack1                  one-cycle grant strobe (high during EXEC)
//   rsp_valid0/rsp_valid1      one-cycle response strobe (high during RESP)
//   rsp_res                    response result, shared by both ports
//   rsp_err                    unsupported opcode, qualified by rsp_valid*
//   flags0/flags1              per-requester flags {CF,ZF,SF,OF}
//   busy                       high whenever the FSM is not in IDLE
//   alu_in1, alu_in2, alu_op   registered drive to the external ALU
//   alu_res, alu_cf..alu_of    result and flags returned by the ALU
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter bit         PRIO_FIXED = 1'b0,
    parameter logic [3:0] OP_ADD     = 4'b0000,
    parameter logic [3:0] OP_PASS    = 4'b1111
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [3:0] op0,
    input  logic       req1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic [3:0] op1,

    output logic       ack0,
    output logic       ack1,
    output logic       rsp_valid0,
    output logic       rsp_valid1,
    output logic [7:0] rsp_res,
    output logic       rsp_err,
    output logic [3:0] flags0,
    output logic [3:0] flags1,
    output logic       busy,

    output logic [7:0] alu_in1,
    output logic [7:0] alu_in2,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_res,
    input  logic       alu_cf,
    input  logic       alu_zf,
    input  logic       alu_sf,
    input  logic       alu_of
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     state;
    logic       last;        // port granted most recently (round-robin pointer)
    logic       owner;       // port that owns the operation in flight
    logic       err;         // in-flight opcode is unsupported
    logic       is_add;      // in-flight opcode updates the owner's flags
    logic [3:0] hold_flags;  // ALU flags sampled at the end of EXEC

    // ------------------------------------------------------------------
    // Arbitration and selection of the winner's operands (combinational)
    // ------------------------------------------------------------------
    logic       any_req;
    logic       grant;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic [3:0] sel_op;
    logic       op_ok;

    // NOTE: every signal gets a default at the top of an always_comb so no
    // path leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        any_req = req0 | req1;
        grant   = 1'b0;
        if (req0 && req1) begin
            // On a tie, round-robin picks the port that was not served last.
            grant = PRIO_FIXED ? 1'b0 : ~last;
        end else if (req1) begin
            grant = 1'b1;
        end

        sel_a  = grant ? a1  : a0;
        sel_b  = grant ? b1  : b0;
        sel_op = grant ? op1 : op0;
        op_ok  = (sel_op == OP_ADD) || (sel_op == OP_PASS);
    end

    // ------------------------------------------------------------------
    // Sequencer: a single registered FSM. Every output is a flop.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge, whatever the statement
    // order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last       <= 1'b1;      // port 0 wins the first tie
            owner      <= 1'b0;
            err        <= 1'b0;
            is_add     <= 1'b0;
            hold_flags <= 4'b0000;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            rsp_res    <= 8'h00;
            rsp_err    <= 1'b0;
            flags0     <= 4'b0000;
            flags1     <= 4'b0000;
            busy       <= 1'b0;
            alu_in1    <= 8'h00;
            alu_in2    <= 8'h00;
            alu_op     <= OP_PASS;
        end else begin
            // The strobes are high for one cycle at most.
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner  <= grant;
                        last   <= grant;
                        ack0   <= ~grant;
                        ack1   <= grant;
                        err    <= ~op_ok;
                        is_add <= (sel_op == OP_ADD);
                        // An unsupported op is acked but never reaches the
                        // ALU. The previous drive stays in place.
                        if (op_ok) begin
                            alu_in1 <= sel_a;
                            alu_in2 <= sel_b;
                            alu_op  <= sel_op;
                        end
                        busy  <= 1'b1;
                        state <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    // The ALU has had a full cycle to settle on the
                    // registered drive. Sample its outputs here.
                    hold_flags <= {alu_cf, alu_zf, alu_sf, alu_of};
                    rsp_res    <= err ? 8'h00 : alu_res;
                    rsp_err    <= err;
                    rsp_valid0 <= ~owner;
                    rsp_valid1 <= owner;
                    state      <= S_RESP;
                end

                S_RESP: begin
                    // Only a successful ADD commits flags, and only for the
                    // owner. is_add is never set together with err.
                    if (is_add) begin
                        if (owner) flags1 <= hold_flags;
                        else       flags0 <= hold_flags;
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
